// File: rtl/alu_pkg.sv
// Shared encodings and the instruction decoder for alu_exec_unit.
// Decode is independent of ALU_MUL_ITER_EN; the top decides whether MULT is executable.
package alu_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_SLTI = 6'h0A;
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_ORI  = 6'h0D;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MUL,
        OP_NOP
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DONE
    } state_e;

    // Source of the second operand
    typedef enum logic [1:0] {
        OPB_REG,
        OPB_SEXT,
        OPB_ZEXT,
        OPB_NONE
    } opb_sel_e;

    typedef struct packed {
        logic [5:0] sel;
        alu_op_e    op;
        opb_sel_e   opb;
        logic       illegal;
    } decode_t;

    function automatic decode_t alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] opcode,
                                           input logic [5:0] funct);
        decode_t d;
        d.sel     = 6'h00;
        d.op      = OP_NOP;
        d.opb     = OPB_NONE;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_RTYPE: begin
                d.sel = funct;
                d.opb = OPB_REG;
                case (funct)
                    FUNCT_ADD:  d.op = OP_ADD;
                    FUNCT_SUB:  d.op = OP_SUB;
                    FUNCT_AND:  d.op = OP_AND;
                    FUNCT_OR:   d.op = OP_OR;
                    FUNCT_SLT:  d.op = OP_SLT;
                    FUNCT_MULT: d.op = OP_MUL;
                    default:    d.illegal = 1'b1;
                endcase
            end
            ALUOP_IMM, ALUOP_BEQ: begin
                d.sel = opcode;
                case (opcode)
                    OPC_BEQ:  begin d.op = OP_SUB; d.opb = OPB_REG;  end
                    OPC_ADDI: begin d.op = OP_ADD; d.opb = OPB_SEXT; end
                    OPC_SLTI: begin d.op = OP_SLT; d.opb = OPB_SEXT; end
                    OPC_ANDI: begin d.op = OP_AND; d.opb = OPB_ZEXT; end
                    OPC_ORI:  begin d.op = OP_OR;  d.opb = OPB_ZEXT; end
                    default:  d.illegal = 1'b1;
                endcase
            end
            default: begin
                // Jump: defined no-op, selection 0, result 0
                d.sel = 6'h00;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
// `done` pulses for one cycle once the final bit has been accumulated.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                mcand_q  <= multiplicand;
                mplier_q <= multiplier;
                acc_q    <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                // Counter stops at the last bit rather than wrapping
                if (cnt_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU control-and-execute stage with valid/ready on both sides.
// ALU_MUL_ITER_EN enables the iterative MULT path; otherwise MULT decodes as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

`ifdef ALU_MUL_ITER_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    state_e           accept_state;
    decode_t          dec;
    logic             accept;
    logic             take;
    logic [WIDTH-1:0] opb_eff;
    logic [WIDTH-1:0] exec_res;

    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [5:0]       isel_q;
    logic             ill_q;

    logic [5:0]       sel_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic             unused_instr;
    assign unused_instr = ^instruction[25:16];

    assign in_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign take     = (state_q == ST_DONE) && out_ready;

    always_comb begin
        dec = alu_decode(alu_op, instruction[31:26], instruction[5:0]);
        if (!MUL_EN && dec.op == OP_MUL) begin
            dec.op      = OP_NOP;
            dec.illegal = 1'b1;
        end
    end

    always_comb begin
        opb_eff = '0;
        case (dec.opb)
            OPB_REG:  opb_eff = op_b;
            OPB_SEXT: opb_eff = WIDTH'($signed(instruction[15:0]));
            OPB_ZEXT: opb_eff = WIDTH'(instruction[15:0]);
            default:  opb_eff = '0;
        endcase
    end

    assign accept_state = (dec.op == OP_MUL) ? ST_MUL : ST_EXEC;

    always_comb begin
        exec_res = '0;
        case (op_q)
            OP_ADD:  exec_res = a_q + b_q;
            OP_SUB:  exec_res = a_q - b_q;
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_SLT:  exec_res = WIDTH'($signed(a_q) < $signed(b_q));
            default: exec_res = '0;
        endcase
    end

`ifdef ALU_MUL_ITER_EN
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign mul_start = accept && (dec.op == OP_MUL);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .start       (mul_start),
        .multiplicand(op_a),
        .multiplier  (opb_eff),
        .busy        (mul_busy),
        .done        (mul_done),
        .product     (mul_product)
    );
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = accept_state;
            ST_EXEC: state_d = ST_DONE;
            ST_MUL: begin
`ifdef ALU_MUL_ITER_EN
                // An idle engine without done can only mean it lost the op
                if (mul_done) begin
                    state_d = ST_DONE;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: if (take) state_d = accept ? accept_state : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            a_q       <= '0;
            b_q       <= '0;
            isel_q    <= 6'h00;
            ill_q     <= 1'b0;
            sel_q     <= 6'h00;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= dec.op;
                a_q    <= op_a;
                b_q    <= opb_eff;
                isel_q <= dec.sel;
                ill_q  <= dec.illegal;
            end
            // Visible result fields change only on entry to DONE
            if (state_q == ST_EXEC) begin
                sel_q     <= isel_q;
                result_q  <= exec_res;
                zero_q    <= (exec_res == '0);
                illegal_q <= ill_q;
            end
`ifdef ALU_MUL_ITER_EN
            else if (state_q == ST_MUL && mul_done) begin
                sel_q     <= isel_q;
                result_q  <= mul_product;
                zero_q    <= (mul_product == '0);
                illegal_q <= 1'b0;
            end
`endif
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign sel       = sel_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); expectations follow ALU_MUL_ITER_EN.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
`ifdef ALU_MUL_ITER_EN
    localparam int          MUL_LAT  = WIDTH + 2;
    localparam logic [31:0] MUL_RES  = 32'h0005_000F;
    localparam logic        MUL_ZERO = 1'b0;
    localparam logic        MUL_ILL  = 1'b0;
`else
    localparam int          MUL_LAT  = 2;
    localparam logic [31:0] MUL_RES  = 32'h0000_0000;
    localparam logic        MUL_ZERO = 1'b1;
    localparam logic        MUL_ILL  = 1'b1;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [31:0]      instruction;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       sel;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .instruction(instruction),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Waits (bounded) for out_valid; returns edges counted from the accept edge
    task automatic wait_valid(output int edges);
        edges = 1;
        while (edges < 100) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [5:0] exp_sel, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ill);
        int edges;
        @(negedge clk);
        alu_op = aop; instruction = ins; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(edges);
        check({tag, ".lat"}, 64'(edges), 64'(exp_lat));
        check({tag, ".sel"}, 64'(sel), 64'(exp_sel));
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".zero"}, 64'(zero), 64'(exp_zero));
        check({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
        $display("%s: lat=%0d sel=%h result=%h zero=%b illegal=%b",
                 tag, edges, sel, result, zero, illegal);
    endtask

    initial begin
        int edges;
        int rises;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; instruction = '0; op_a = '0; op_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'(0));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.sel", 64'(sel), 64'(0));
        check("rst.result", 64'(result), 64'(0));
        check("rst.zero", 64'(zero), 64'(0));
        check("rst.illegal", 64'(illegal), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst.in_ready_after", 64'(in_ready), 64'(1));
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);

        run_op("add",   2'b10, 32'h0000_0020, 32'd5, 32'd7, 2, 6'h20, 32'd12, 1'b0, 1'b0);
        run_op("beq",   2'b01, 32'h1000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 6'h04, 32'd0, 1'b1, 1'b0);
        run_op("slti",  2'b00, 32'h2800_FFFF, 32'hFFFF_FFFE, 32'h1234_5678, 2, 6'h0A, 32'd1, 1'b0, 1'b0);
        run_op("addi",  2'b00, 32'h2000_FFFC, 32'd10, 32'h0000_0100, 2, 6'h08, 32'd6, 1'b0, 1'b0);
        run_op("andi",  2'b00, 32'h3000_F0F0, 32'hFFFF_FFFF, 32'd0, 2, 6'h0C, 32'h0000_F0F0, 1'b0, 1'b0);
        run_op("ori",   2'b00, 32'h3400_8001, 32'h1234_0000, 32'hFFFF_FFFF, 2, 6'h0D, 32'h1234_8001, 1'b0, 1'b0);
        run_op("sub",   2'b10, 32'h0000_0022, 32'd3, 32'd5, 2, 6'h22, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("and",   2'b10, 32'h0000_0024, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, 6'h24, 32'hF000_F000, 1'b0, 1'b0);
        run_op("or",    2'b10, 32'h0000_0025, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, 6'h25, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("slt_n", 2'b10, 32'h0000_002A, 32'h8000_0000, 32'd1, 2, 6'h2A, 32'd1, 1'b0, 1'b0);
        run_op("slt_p", 2'b10, 32'h0000_002A, 32'd1, 32'h8000_0000, 2, 6'h2A, 32'd0, 1'b1, 1'b0);
        run_op("addwrap", 2'b10, 32'h0000_0020, 32'hFFFF_FFFF, 32'd1, 2, 6'h20, 32'd0, 1'b1, 1'b0);
        run_op("mult",  2'b10, 32'h0000_0018, 32'h0001_0003, 32'h0000_0005, MUL_LAT, 6'h18, MUL_RES, MUL_ZERO, MUL_ILL);
        run_op("jump",  2'b11, 32'h0800_0020, 32'd9, 32'd9, 2, 6'h00, 32'd0, 1'b1, 1'b0);
        run_op("bad3f", 2'b10, 32'h0000_003F, 32'd9, 32'd4, 2, 6'h3F, 32'd0, 1'b1, 1'b1);

        // Backpressure: ADD held in DONE, then simultaneous take and accept of SUB
        @(negedge clk);
        alu_op = 2'b10; instruction = 32'h0000_0020; op_a = 32'd100; op_b = 32'd23;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(edges);
        check("bp.lat", 64'(edges), 64'(2));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_valid", 64'(out_valid), 64'(1));
            check("bp.hold_result", 64'(result), 64'(123));
            check("bp.in_ready", 64'(in_ready), 64'(0));
        end
        $display("backpressure: held result=%h out_valid=%b in_ready=%b", result, out_valid, in_ready);
        alu_op = 2'b10; instruction = 32'h0000_0022; op_a = 32'd50; op_b = 32'd8;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check("bp.in_ready_take", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp.released", 64'(out_valid), 64'(0));
        @(posedge clk);
        wait_valid(edges);
        edges = edges + 1;
        check("bp.next_lat", 64'(edges), 64'(2));
        check("bp.next_result", 64'(result), 64'(42));
        check("bp.next_sel", 64'(sel), 64'(6'h22));
        $display("take+accept: lat=%0d sel=%h result=%h", edges, sel, result);

        // Reset during MULT (in MUL with the multiplier on, held in DONE otherwise)
        @(negedge clk);
        alu_op = 2'b10; instruction = 32'h0000_0018; op_a = 32'h0001_0003; op_b = 32'd5;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("mrst.in_ready_in_rst", 64'(in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("mrst.out_valid", 64'(out_valid), 64'(0));
        check("mrst.sel", 64'(sel), 64'(0));
        check("mrst.result", 64'(result), 64'(0));
        check("mrst.zero", 64'(zero), 64'(0));
        check("mrst.illegal", 64'(illegal), 64'(0));
        rst = 1'b0; out_ready = 1'b1;
        rises = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) rises++;
        end
        check("mrst.no_result", 64'(rises), 64'(0));
        check("mrst.in_ready_after", 64'(in_ready), 64'(1));
        $display("reset mid-op: out_valid rises=%0d", rises);
        run_op("add_after_rst", 2'b10, 32'h0000_0020, 32'd40, 32'd2, 2, 6'h20, 32'd42, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered ALU control-and-execute stage for the single-issue MIPS core, sitting between decode and writeback. Combines the ALUOp/instruction decode of the existing combinational controller with an operand datapath. Generalised to a parametrised data width, a valid/ready handshake on both sides, a defined jump/no-op encoding in place of X, an illegal-op flag, and an optional iterative multi-cycle multiply.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; legal range 8..64.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction and its operands are presented.
- `in_ready` out 1: the block accepts on `in_valid && in_ready` at a rising edge.
- `alu_op` in 2: 2'b10 R-type, 2'b00 immediate, 2'b01 BEQ, 2'b11 jump.
- `instruction` in 32: raw instruction word.
- `op_a` in WIDTH: rs operand.
- `op_b` in WIDTH: rt operand; ignored for immediate ops.
- `out_valid` out 1: result fields are valid.
- `out_ready` in 1: consumer takes the result on `out_valid && out_ready`.
- `sel` out 6: registered selection code (funct or opcode), 6'h00 for jump.
- `result` out WIDTH: ALU result.
- `zero` out 1: `result == 0`; used for the BEQ decision.
- `illegal` out 1: the selection code is unsupported.

## Operation
- Decode at the accept edge. The ALUOp to selection mapping is:
  - 10 selects `instruction[5:0]`.
  - 00 and 01 select `instruction[31:26]`.
  - 11 selects 6'h00 with result 0 and `illegal` = 0.
- Supported codes:
  - R-type: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, MULT 0x18.
  - Immediate: ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D.
  - BEQ: opcode 0x04, executes SUB.
- Immediate operand: `instruction[15:0]` is sign-extended to WIDTH for ADDI and SLTI, and zero-extended for ANDI and ORI.
- Arithmetic wraps modulo 2^WIDTH; overflow is not flagged. SLT/SLTI compare signed and return 1 or 0.
- MULT returns the low WIDTH bits of the unsigned product.
- Any unsupported code sets `illegal` = 1, forces `result` = 0 (so `zero` = 1), and completes in single-cycle latency.
- FSM states IDLE, EXEC, MUL, DONE:
  - IDLE goes to EXEC on accept of a non-MULT op, or to MUL on accept of MULT.
  - EXEC goes to DONE after one cycle.
  - MUL goes to DONE after WIDTH iterations.
  - DONE goes to IDLE on take with no new accept.
  - DONE goes to EXEC or MUL on take with a simultaneous accept.
- `in_ready` = !rst && (state==IDLE || (state==DONE && out_ready)).
- `out_valid` is high exactly in DONE. Result fields hold stable until taken.

## Timing
- Reset values: state IDLE, `out_valid` 0, `sel` 6'h00, `result` 0, `zero` 0, `illegal` 0. `in_ready` is 0 while `rst` is high and 1 in the cycle after.
- Latency, counted as edges from the accept edge to the first cycle with `out_valid` high:
  - 2 for single-cycle ops (accept edge, then the EXEC edge).
  - WIDTH+2 for MULT (accept edge, WIDTH MUL edges, then DONE).
- Back-to-back throughput for single-cycle ops is one result per 2 cycles.
- If a take and an accept occur at the same edge, the held result is released and the new instruction is latched. No bubble beyond EXEC.
- Backpressure: DONE holds indefinitely while `out_ready` = 0, and `in_ready` stays 0.
- Reset mid-operation (EXEC, MUL or DONE) aborts the operation, returns all outputs to reset values on the next edge, and never produces a partial result.
- The MUL iteration counter runs 0..WIDTH-1 with no wrap; it is cleared on every MULT accept.

## Configuration
- `ALU_MUL_ITER_EN` defined: MULT (0x18) runs the iterative shift-add path with WIDTH+2 latency.
- Macro undefined: the multiplier and MUL state are not compiled in. 0x18 is treated as unsupported, giving `illegal` = 1 and `result` = 0 with single-cycle latency.

## Structure
- Package `alu_pkg` holds:
  - ALUOp constants (`ALUOP_RTYPE`, `ALUOP_IMM`, `ALUOP_BEQ`, `ALUOP_JUMP`).
  - The funct/opcode localparams listed above.
  - The internal operation enum (ADD, SUB, AND, OR, SLT, MUL, NOP).
  - The FSM state enum.
- One sub-module, `alu_mul_iter`:
  - Parameter WIDTH; ports `start` and `busy`.
  - Processes one multiplier bit per cycle and asserts `done` on its final iteration.
  - Instantiated only under `ALU_MUL_ITER_EN`.

## Test plan
- Reset, then ADD R-type (funct 0x20) with `op_a`=5, `op_b`=7, `out_ready`=1 -> `out_valid` in the cycle after edge 2, `result`=12, `sel`=0x20, `zero`=0.
- BEQ (opcode 0x04) with `op_a`=`op_b`=0xDEADBEEF -> `result`=0, `zero`=1, `sel`=0x04. Then SLTI with imm 0xFFFF and `op_a`=0xFFFFFFFE -> `result`=1.
- MULT with 0x0001_0003 × 0x0000_0005 (WIDTH=32, macro on) -> `out_valid` after WIDTH+2=34 edges, `result`=0x0005_000F. With the macro off -> `illegal`=1, `result`=0 after 2 edges.
- Jump (`alu_op`=11) followed by unsupported funct 0x3F -> first `sel`=0x00 and `illegal`=0; second `illegal`=1 and `result`=0.
- `out_ready` held low for 5 cycles in DONE -> result stable and `in_ready`=0. Then raise `out_ready` with `in_valid` high -> take and accept on the same edge; the next result follows 2 edges later.
- Assert `rst` in the 10th MUL cycle -> `out_valid` never rises for that op, outputs return to reset values, and a new ADD completes normally.
